// File: rtl/opb_register_bank_simulink2ppc_pkg.sv
// Shared constants for the Simulink-to-PPC OPB register bank: word offsets,
// CTRL bit positions and the OPB slave handshake states.
package opb_register_bank_simulink2ppc_pkg;

    localparam int WORD_W        = 32;
    localparam int CTRL_SNAP_BIT = 0;
    localparam int CTRL_AUTO_BIT = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } opb_state_e;

    function automatic int status_off(input int num_regs);
        return num_regs;
    endfunction

    function automatic int ctrl_off(input int num_regs);
        return num_regs + 1;
    endfunction

    function automatic int tstamp_off(input int num_regs);
        return num_regs + 2;
    endfunction

    // Decoded words: SNAP[0..N-1], STATUS, CTRL, TSTAMP.
    function automatic int num_words(input int num_regs);
        return num_regs + 3;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave handshake: window decode, select->ack (one cycle later), and a
// registered read mux loaded when the transfer is accepted.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | waiting for an in-window OPB_select
//   ST_ACK  | xferAck asserted; write side effects take place here
module opb_slave_ack_fsm
    import opb_register_bank_simulink2ppc_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h01080900,
    parameter logic [31:0] C_HIGHADDR = 32'h010809FF,
    parameter int          NUM_WORDS  = 7
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sel,
    input  logic                              rnw,
    input  logic [31:0]                       addr,
    input  logic [31:0]                       wdata,
    input  logic                              be_low,
    input  logic [NUM_WORDS-1:0][WORD_W-1:0]  rd_words,
    output logic                              ack,
    output logic                              rd_en,
    output logic                              wr_en,
    output logic [29:0]                       off,
    output logic [31:0]                       wr_data,
    output logic                              wr_be_low,
    output logic [31:0]                       rd_data
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    opb_state_e  state_q, state_nx;
    logic [31:0] diff;
    logic [29:0] off_full;
    logic        start;
    logic        ack_int;
    logic        rnw_q;
    logic [31:0] rd_q;
    logic        unused_ok;

    assign diff      = addr - C_BASEADDR;
    assign off_full  = diff[31:2];
    assign start     = sel && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign unused_ok = ^diff[1:0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        ack_int  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_nx = ST_ACK;
            ST_ACK: begin
                ack_int  = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Transfer attributes are latched at acceptance so the ack cycle does not
    // depend on the master holding the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            off       <= '0;
            rnw_q     <= 1'b0;
            wr_data   <= '0;
            wr_be_low <= 1'b0;
            rd_q      <= '0;
        end else if (state_q == ST_IDLE && start) begin
            off       <= off_full;
            rnw_q     <= rnw;
            wr_data   <= wdata;
            wr_be_low <= be_low;
            if (rnw && off_full < 30'(NUM_WORDS))
                rd_q <= rd_words[off_full[IDX_W-1:0]];
            else
                rd_q <= '0;
        end
    end

    // Reset gates the ack combinationally so an aborted transfer never acks.
    assign ack     = ack_int && !rst;
    assign rd_en   = ack && rnw_q;
    assign wr_en   = ack && !rnw_q;
    assign rd_data = rd_en ? rd_q : '0;

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// Multi-channel Simulink-to-PPC register bank with atomic snapshot, sticky
// clear-on-read update flags and CTRL. Optional macro: SNAPSHOT_TIMESTAMP_EN.
module opb_register_bank_simulink2ppc
    import opb_register_bank_simulink2ppc_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01080900,
    parameter logic [31:0] C_HIGHADDR   = 32'h010809FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter int          C_DATA_WIDTH = 32,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                               OPB_Clk,
    input  logic                               OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]            OPB_ABus,
    input  logic [0:3]                         OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]            OPB_DBus,
    input  logic                               OPB_RNW,
    input  logic                               OPB_select,
    input  logic                               OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]            Sl_DBus,
    output logic                               Sl_xferAck,
    output logic                               Sl_errAck,
    output logic                               Sl_retry,
    output logic                               Sl_toutSup,
    input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] user_data_in,
    input  logic [C_NUM_REGS-1:0]              user_valid
);

    localparam int N          = C_NUM_REGS;
    localparam int W          = C_DATA_WIDTH;
    localparam int NW         = num_words(N);
    localparam int STATUS_OFF = status_off(N);
    localparam int CTRL_OFF   = ctrl_off(N);
    localparam int TSTAMP_OFF = tstamp_off(N);
    localparam bit unused_family = (C_FAMILY == "");

    logic [N-1:0][W-1:0]       live_q, snap_q;
    logic [N-1:0]              status_q, status_clr;
    logic                      ctrl_auto_q, snap_pend_q, do_snap;
    logic [NW-1:0][WORD_W-1:0] rd_words;
    logic                      ack, rd_en, wr_en, wr_be_low, ctrl_wr;
    logic [29:0]               off;
    logic [31:0]               wr_data, rd_data;
    logic                      unused_ok;

    opb_slave_ack_fsm #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR),
        .NUM_WORDS  (NW)
    ) u_ack_fsm (
        .clk       (OPB_Clk),
        .rst       (OPB_Rst),
        .sel       (OPB_select),
        .rnw       (OPB_RNW),
        .addr      (OPB_ABus),
        .wdata     (OPB_DBus),
        .be_low    (OPB_BE[3]),
        .rd_words  (rd_words),
        .ack       (ack),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .off       (off),
        .wr_data   (wr_data),
        .wr_be_low (wr_be_low),
        .rd_data   (rd_data)
    );

    assign Sl_DBus    = rd_data;
    assign Sl_xferAck = ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign unused_ok  = ^{OPB_seqAddr, OPB_BE[0:2], wr_data[31:2], unused_family};

    assign ctrl_wr = wr_en && wr_be_low && (off == 30'(CTRL_OFF));
    assign do_snap = snap_pend_q || ctrl_auto_q;
    // Only the bits actually returned are cleared, so a flag set while the
    // read was being accepted is not lost.
    assign status_clr = (rd_en && off == 30'(STATUS_OFF)) ? rd_data[N-1:0] : '0;

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            live_q      <= '0;
            snap_q      <= '0;
            status_q    <= '0;
            ctrl_auto_q <= 1'b0;
            snap_pend_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++)
                if (user_valid[i]) live_q[i] <= user_data_in[i*W +: W];
            if (do_snap) snap_q <= live_q;
            status_q    <= (status_q & ~status_clr) | user_valid;
            snap_pend_q <= ctrl_wr && wr_data[CTRL_SNAP_BIT];
            if (ctrl_wr) ctrl_auto_q <= wr_data[CTRL_AUTO_BIT];
        end
    end

`ifdef SNAPSHOT_TIMESTAMP_EN
    logic [31:0] cycle_cnt_q, tstamp_q;

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            cycle_cnt_q <= '0;
            tstamp_q    <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (do_snap) tstamp_q <= cycle_cnt_q;
        end
    end
`endif

    always_comb begin
        rd_words = '0;
        for (int i = 0; i < N; i++)
            rd_words[i] = WORD_W'(snap_q[i]);
        rd_words[STATUS_OFF]                = WORD_W'(status_q);
        rd_words[CTRL_OFF][CTRL_AUTO_BIT]   = ctrl_auto_q;
`ifdef SNAPSHOT_TIMESTAMP_EN
        rd_words[TSTAMP_OFF] = tstamp_q;
`else
        rd_words[TSTAMP_OFF] = '0;
`endif
    end

endmodule

// File: doc/opb_register_bank_simulink2ppc.md
Name: opb_register_bank_simulink2ppc

Overview:
- Multi-channel successor to the single-word Simulink-to-PPC status register.
- Captures C_NUM_REGS user words from fabric logic and exposes them to software as an OPB slave register window.
- Adds atomic multi-channel snapshot, sticky per-channel update flags (clear-on-read) and a control register.
- Sits between Simulink-generated fabric and the PPC OPB bus, e.g. for grouped GbE error/packet counters.

Parameters:
C_BASEADDR, 32'h01080900, base of byte window
C_HIGHADDR, 32'h010809FF, top of byte window
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width
C_NUM_REGS, 4, user channels, 1..32
C_DATA_WIDTH, 32, bits per channel, 1..32; zero-extended on read
C_FAMILY, "virtex5", target family (informational)

Ports:
OPB_Clk  in  1  sole clock; user logic is synchronous to it
OPB_Rst  in  1  synchronous, active-high reset
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables; BE[3] covers DBus[24:31]
OPB_DBus  in  [0:31]  write data; DBus[31] is bit 0
OPB_RNW  in  1  1 = read
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data; zero except in ack cycle
Sl_xferAck  out  1  one-cycle transfer acknowledge
Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
user_data_in  in  C_NUM_REGS*C_DATA_WIDTH  channel i = bits [i*W +: W]
user_valid  in  C_NUM_REGS  per-channel capture strobe

Behaviour:
- Clocking/reset: one clock, OPB_Clk; OPB_Rst synchronous, active-high.
- Reset: all live, snapshot and status registers = 0; control = 0; FSM = IDLE; all Sl_* outputs = 0. Reset during ACK aborts the transfer: no ack is issued and no register side effects occur.
- Live capture: live[i] <= user_data_in channel i on each cycle with user_valid[i]=1.
- Register map, word offset = (ABus - C_BASEADDR) >> 2:
  - 0..N-1: SNAP[i], read-only.
  - N: STATUS, bit i = sticky update flag; read clears.
  - N+1: CTRL, R/W.
  - Other in-window offsets: read 0, writes ignored, still acked.
- CTRL bits:
  - bit0 SNAP: write 1 = one-shot snapshot; reads 0.
  - bit1 AUTO: 1 = snapshot on every cycle. Writes honoured only when BE[3]=1.
- Snapshot: all SNAP[i] <= live[i] in the same cycle (atomic), one cycle after the CTRL write ack. Data captured in that same cycle is not included.
- STATUS: bit i sets on user_valid[i]; clears on the ack cycle of a STATUS read. Simultaneous set and clear → set wins; the read returns the pre-clear value.
- OPB FSM:
  - IDLE → ACK when OPB_select=1 and the address is in [C_BASEADDR, C_HIGHADDR].
  - ACK: Sl_xferAck=1 for exactly one cycle; Sl_DBus = registered read data (reads only); write takes effect. Then → IDLE.
  - Access latency: ack 1 cycle after select is sampled.
  - Back-to-back: after the ACK cycle a new select is sampled in IDLE, giving at most one ack per 2 cycles.
  - Out-of-window select: never acked, so the bus times out upstream.

Optional Feature:
- SNAPSHOT_TIMESTAMP_EN defined:
  - Free-running 32-bit cycle counter, reset to 0, wraps at 2^32-1 → 0.
  - Captured into TSTAMP at offset N+2 on every snapshot; read-only.
- Undefined: no counter; offset N+2 reads 0.

Decomposition:
- Shared package: register offset constants (STATUS_OFF, CTRL_OFF, TSTAMP_OFF as functions of C_NUM_REGS), CTRL bit indices, FSM state encoding (IDLE/ACK).
- Sub-module opb_slave_ack_fsm: address decode, select→ack handshake, read mux register.
- Channel storage stays in the top level.

Test Plan:
- Reset then read offsets 0..N+1 → all return 0; xferAck pulses once per read, 1 cycle after select.
- user_valid=4'b0101 with ch0=0xDEADBEEF, ch2=0x12345678; write CTRL=0x1; read SNAP0/SNAP2 → 0xDEADBEEF/0x12345678, SNAP1=0.
- Read STATUS → 0x5; read again → 0x0. Repeat with user_valid[0]=1 in the clear cycle → second read returns 0x1.
- Write CTRL=0x1 with BE=4'b1110 → no snapshot; SNAP values unchanged.
- Set AUTO (CTRL=0x2); change ch1 to 0xA5 → SNAP1=0xA5 two cycles later.
- With SNAPSHOT_TIMESTAMP_EN: snapshot at cycle 100 after reset → TSTAMP = 100 ± pipeline offset as specified; assert OPB_Rst mid-ACK → no xferAck and counter = 0 next cycle.
